// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx between NUM_REQ byte sources.
// One axiiv strobe per byte, then wait for tx_done; a watchdog flags a stuck transmitter.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned ID_W         = 2,
  parameter int unsigned DONE_TIMEOUT = 2000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_axiiv,
  output logic [7:0]           tx_axiid,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 timeout_err
);

  localparam int unsigned WD_W = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic              lock;
  logic [WD_W-1:0]   wd_cnt;

  logic              found;
  logic [ID_W-1:0]   rr_win;
  logic [ID_W-1:0]   cand;
  logic [NUM_REQ-1:0] vshift;
  logic [NUM_REQ-1:0] gshift;
  logic [NUM_REQ-1:0] lshift;
  logic [8*NUM_REQ-1:0] dshift;
  logic [ID_W-1:0]   sel;
  logic              accept;
  logic [7:0]        sel_data;
  logic              sel_last;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
    return (x == ID_W'(NUM_REQ - 1)) ? '0 : x + ID_W'(1);
  endfunction

  // First valid requester scanning upward from rr_ptr with wrap.
  always_comb begin
    found  = 1'b0;
    rr_win = '0;
    cand   = rr_ptr;
    vshift = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      vshift = req_valid >> cand;
      if (!found && vshift[0]) begin
        found  = 1'b1;
        rr_win = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  // A held lock restricts the handshake to the current owner.
  always_comb begin
    gshift   = req_valid >> grant_id;
    sel      = lock ? grant_id : rr_win;
    accept   = (state == IDLE) && (lock ? gshift[0] : found);
    dshift   = req_data >> {sel, 3'b000};
    lshift   = req_last >> sel;
    sel_data = dshift[7:0];
    sel_last = lshift[0];
    req_ready = accept ? (NUM_REQ'(1) << sel) : '0;
  end

  assign busy = (state != IDLE) || lock;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      lock        <= 1'b0;
      wd_cnt      <= '0;
      tx_axiiv    <= 1'b0;
      tx_axiid    <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      tx_axiiv <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_axiid <= sel_data;
            grant_id <= sel;
            lock     <= ~sel_last;
            tx_axiiv <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            state <= IDLE;
            if (!lock) rr_ptr <= wrap_inc(grant_id);
          end else if (wd_cnt == WD_W'(DONE_TIMEOUT - 1)) begin
            // Transmitter never answered: give up on the packet and move on.
            timeout_err <= 1'b1;
            lock        <= 1'b0;
            rr_ptr      <= wrap_inc(grant_id);
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues from a vector table,
// a uart_tx model with configurable done latency, and an in-order scoreboard.
module tb_uart_tx_arbiter;

  localparam int unsigned NR  = 3;
  localparam int unsigned DLY = 5;

  typedef struct {
    int unsigned scen;
    int unsigned req;
    logic [7:0]  data;
    logic        last;
    int          gap;
    int unsigned exp_req;
    logic [7:0]  exp_byte;
  } vec_t;

  typedef struct {
    int unsigned req;
    logic [7:0]  data;
    logic        last;
    int          gap;
  } pend_t;

  typedef struct {
    int unsigned req;
    logic [7:0]  data;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            tx_axiiv;
  logic [7:0]      tx_axiid;
  logic            tx_done;
  logic            busy;
  logic [1:0]      grant_id;
  logic            timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NR), .ID_W(2), .DONE_TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_axiiv(tx_axiiv),
    .tx_axiid(tx_axiid), .tx_done(tx_done), .busy(busy),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    acc_cyc = 0;
  int    n_strobes = 0;
  int    done_cnt = 0;
  int    silent_cnt = 0;
  bit    stray_done = 0;
  bit    have_inflight = 0;
  bit    chk_hold = 0;
  bit    prev_axiiv = 0;
  logic [7:0] hold_byte = '0;
  bit [NR-1:0] acc = '0;
  int    gap_left[NR];
  exp_t  inflight;
  pend_t pq[$];
  exp_t  exp_q[$];
  vec_t  vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int find(input int unsigned r);
    foreach (pq[j]) if (pq[j].req == r) return j;
    return -1;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Requester drivers and uart_tx model, updated just after each rising edge.
  always @(posedge clk) begin
    int k;
    #1;
    tx_done = 1'b0;
    if (stray_done) begin
      tx_done    = 1'b1;
      stray_done = 0;
    end
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) tx_done = 1'b1;
    end
    for (int i = 0; i < int'(NR); i++) begin
      if (acc[i]) begin
        acc[i] = 1'b0;
        k = find(i);
        if (k >= 0) pq.delete(k);
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'($urandom);
        req_last[i]         = 1'($urandom);
      end
      if (!req_valid[i]) begin
        k = find(i);
        if (k >= 0) begin
          if (gap_left[i] < 0) gap_left[i] = pq[k].gap;
          if (gap_left[i] == 0) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = pq[k].data;
            req_last[i]        = pq[k].last;
            gap_left[i]        = -1;
          end else begin
            gap_left[i]--;
          end
        end
      end
    end
  end

  // Scoreboard: grants and strobes checked against the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      cyc++;
      chk("ready_onehot", 32'($onehot0(req_ready)), 1);
      if (req_ready != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'(req_ready), 0);
        end else begin
          inflight = exp_q.pop_front();
          chk("grant_req", 32'(req_ready), 32'(3'b001 << inflight.req));
          have_inflight = 1;
          acc_cyc = cyc;
        end
        for (int i = 0; i < int'(NR); i++) acc[i] = req_ready[i] & req_valid[i];
      end
      if (tx_axiiv) begin
        chk("single_strobe", 32'(prev_axiiv), 0);
        chk("strobe_expected", 32'(have_inflight), 1);
        if (have_inflight) begin
          chk("tx_byte", 32'(tx_axiid), 32'(inflight.data));
          chk("grant_id", 32'(grant_id), inflight.req);
          chk("strobe_latency", 32'(cyc - acc_cyc), 1);
          hold_byte = inflight.data;
        end
        have_inflight = 0;
        n_strobes++;
        if (silent_cnt > 0) begin
          silent_cnt--;
          chk_hold = 0;
        end else begin
          done_cnt = DLY;
          chk_hold = 1;
        end
      end
      if (tx_done && chk_hold) begin
        chk("byte_held", 32'(tx_axiid), 32'(hold_byte));
        chk_hold = 0;
      end
      prev_axiiv = tx_axiiv;
    end
  end

  task automatic do_reset(input bit keep_model);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pq.delete();
    exp_q.delete();
    have_inflight = 0;
    chk_hold = 0;
    prev_axiiv = 0;
    acc = '0;
    req_valid = '0;
    for (int i = 0; i < int'(NR); i++) gap_left[i] = -1;
    if (!keep_model) begin
      done_cnt = 0;
      silent_cnt = 0;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    chk("reset_outs", {req_ready, tx_axiiv, tx_axiid, busy, grant_id, timeout_err}, 0);
  endtask

  task automatic load(input int unsigned s);
    foreach (vecs[j]) begin
      if (vecs[j].scen == s) begin
        pq.push_back('{vecs[j].req, vecs[j].data, vecs[j].last, vecs[j].gap});
        exp_q.push_back('{vecs[j].exp_req, vecs[j].exp_byte});
      end
    end
  endtask

  task automatic wait_strobes(input int n);
    int k = 0;
    while (n_strobes < n && k < 2000) begin
      tick();
      k++;
    end
    chk("strobe_wait", 32'(n_strobes >= n), 1);
  endtask

  task automatic wait_all();
    int k = 0;
    while (!(exp_q.size() == 0 && !have_inflight && done_cnt == 0 && !busy) && k < 3000) begin
      tick();
      k++;
    end
    chk("drain", 32'(exp_q.size() == 0 && !have_inflight && !busy), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int k;
    vecs[0]  = '{2, 1, 8'h3F, 1'b1, 0,  1, 8'h3F};
    vecs[1]  = '{3, 0, 8'h01, 1'b1, 0,  2, 8'h02};
    vecs[2]  = '{3, 2, 8'h02, 1'b1, 0,  0, 8'h01};
    vecs[3]  = '{4, 0, 8'hA0, 1'b1, 0,  0, 8'hA0};
    vecs[4]  = '{4, 1, 8'hA1, 1'b1, 0,  1, 8'hA1};
    vecs[5]  = '{4, 2, 8'hA2, 1'b1, 0,  2, 8'hA2};
    vecs[6]  = '{4, 0, 8'hA0, 1'b1, 0,  0, 8'hA0};
    vecs[7]  = '{5, 0, 8'h10, 1'b0, 0,  0, 8'h10};
    vecs[8]  = '{5, 2, 8'hF0, 1'b1, 0,  0, 8'h11};
    vecs[9]  = '{5, 0, 8'h11, 1'b0, 50, 0, 8'h12};
    vecs[10] = '{5, 0, 8'h12, 1'b1, 0,  2, 8'hF0};
    vecs[11] = '{6, 1, 8'h55, 1'b1, 0,  1, 8'h55};
    vecs[12] = '{6, 2, 8'h77, 1'b1, 0,  2, 8'h77};
    vecs[13] = '{7, 0, 8'h21, 1'b0, 0,  0, 8'h21};
    vecs[14] = '{8, 0, 8'h33, 1'b1, 0,  0, 8'h33};

    rst = 1'b0;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    tx_done = 1'b0;
    for (int i = 0; i < int'(NR); i++) gap_left[i] = -1;
    repeat (3) tick();
    chk("reset_hold", {req_ready, tx_axiiv, tx_axiid, busy, grant_id, timeout_err}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Quiet link after reset.
    repeat (100) begin
      tick();
      chk("idle_outs", {req_ready, tx_axiiv, busy, grant_id, timeout_err}, 0);
    end

    // Single byte, then rr_ptr=2 shown by req 2 beating req 0.
    base = n_strobes;
    load(2);
    wait_strobes(base + 1);
    chk("busy_in_wait", 32'(busy), 1);
    wait_all();
    load(3);
    wait_all();
    chk("rr_count", 32'(n_strobes - base), 3);

    // Round-robin over three single-byte packets plus a reload.
    do_reset(0);
    base = n_strobes;
    load(4);
    wait_all();
    chk("rr4_count", 32'(n_strobes - base), 4);

    // Packet lock survives a 50-cycle valid gap from the owner.
    do_reset(0);
    base = n_strobes;
    load(5);
    wait_strobes(base + 1);
    repeat (25) tick();
    chk("lock_busy", 32'(busy), 1);
    chk("lock_no_ready", 32'(req_ready), 0);
    chk("lock_strobes", 32'(n_strobes - base), 1);
    wait_all();
    chk("lock_count", 32'(n_strobes - base), 4);

    // Watchdog: transmitter silent after 0x55.
    do_reset(0);
    base = n_strobes;
    silent_cnt = 1;
    load(6);
    wait_strobes(base + 1);
    k = 0;
    while (!timeout_err && k < 300) begin
      tick();
      k++;
    end
    chk("wd_latency", 32'(k), 101);
    wait_all();
    chk("wd_err_sticky", 32'(timeout_err), 1);
    base = n_strobes;
    stray_done = 1;
    repeat (5) tick();
    chk("stray_busy", 32'(busy), 0);
    chk("stray_strobes", 32'(n_strobes - base), 0);
    chk("stray_err", 32'(timeout_err), 1);
    chk("stray_grant", 32'(grant_id), 2);

    // Reset during WAIT_DONE with a lock held; late done must be ignored.
    do_reset(0);
    base = n_strobes;
    load(7);
    wait_strobes(base + 1);
    tick();
    chk("mid_busy", 32'(busy), 1);
    do_reset(1);
    repeat (10) tick();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_err", 32'(timeout_err), 0);
    chk("post_rst_strobes", 32'(n_strobes - base), 1);
    load(8);
    wait_all();
    chk("post_rst_count", 32'(n_strobes - base), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx transmitter between NUM_REQ requesters, for example the solver result streamer and the debug/echo path. It arbitrates round-robin at packet granularity: a granted requester keeps the link until its byte flagged last has been transmitted. It issues one single-cycle axiiv strobe per byte, then waits for the transmitter's done pulse before the next byte. A watchdog flags a transmitter that never reports done.

Parameters:
NUM_REQ, 3, number of requesters (2..8).
ID_W, 2, width of grant_id; must satisfy 2^ID_W >= NUM_REQ.
DONE_TIMEOUT, 2000000, clock cycles to wait for tx_done before declaring an error.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-low (asserted when 0).
req_valid  in  NUM_REQ  per-requester byte-valid.
req_data  in  8*NUM_REQ  byte for requester i, in bits [8i+7:8i].
req_last  in  NUM_REQ  byte closes the packet; releases the lock after it is sent.
req_ready  out  NUM_REQ  one-hot, single-cycle accept strobe.
tx_axiiv  out  1  valid strobe to uart_tx.
tx_axiid  out  8  byte to uart_tx.
tx_done  in  1  transmit-complete pulse from uart_tx.
busy  out  1  high when state is not IDLE or a lock is held.
grant_id  out  ID_W  index of the current or last granted requester.
timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0 at a clk edge), from any state including mid-byte:
  - state=IDLE, rr_ptr=0, lock=0.
  - All outputs 0: req_ready, tx_axiiv, tx_axiid, busy, grant_id, timeout_err.
  - A byte the UART is currently shifting out is abandoned; its tx_done is ignored.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE, lock=0:
  - If any req_valid is high, the winner w is the first valid index scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready[w]=1 combinationally in that cycle; that cycle is the handshake.
  - At the edge, register req_data[w] into tx_axiid and grant_id<=w. Set lock<=~req_last[w]. Go to ISSUE.
- IDLE, lock=1:
  - Only requester grant_id is considered; all other valids are ignored.
  - If req_valid[grant_id]=1, accept it exactly as above.
  - If it stays low, remain in IDLE indefinitely with busy=1.
- ISSUE: tx_axiiv=1 for exactly one cycle with tx_axiid stable, then go to WAIT_DONE.
- Latency: accept cycle N gives tx_axiiv high in cycle N+1.
- WAIT_DONE:
  - tx_axiid is held. tx_done=1 returns the FSM to IDLE.
  - If lock=0 at that moment, rr_ptr<=grant_id+1, wrapping to 0 after NUM_REQ-1.
  - The watchdog counter starts at 0 on entry and increments every cycle.
  - On reaching DONE_TIMEOUT: set timeout_err<=1, clear lock, advance rr_ptr as above, go to IDLE.
- timeout_err clears only on reset.
- tx_done outside WAIT_DONE is ignored.
- Back-to-back bytes:
  - Minimum spacing is tx_done cycle, then accept cycle, then strobe cycle.
  - Requesters must therefore hold valid and data until req_ready.
- req_ready is never asserted outside IDLE. At most one bit is high in any cycle.
- req_data and req_last are sampled only in the accept cycle. Changes at any other time have no effect.
- busy = (state != IDLE) | lock.

Test Plan:
1. Reset hold, then release with all req_valid=0 for 100 cycles -> req_ready=0, tx_axiiv=0, busy=0, grant_id=0, timeout_err=0 throughout.
2. Single byte: req 1 presents 0x3F with last=1 -> req_ready=3'b010 for one cycle; next cycle tx_axiiv=1, tx_axiid=0x3F; busy until the model's tx_done; rr_ptr becomes 2.
3. Round-robin: all three requesters hold single-byte packets 0xA0/0xA1/0xA2 with last=1 -> transmitted order 0xA0, 0xA1, 0xA2, 0xA0 with reloaded data; each gets exactly one req_ready per grant.
4. Packet lock: req 0 sends 0x10, 0x11, 0x12 with last only on 0x12 while req 2 holds 0xF0 -> UART sees 0x10, 0x11, 0x12, 0xF0; req 0 drops valid for 50 cycles between bytes -> req 2 is still not granted and busy stays 1.
5. Watchdog (DONE_TIMEOUT=100 in bench): the model never pulses tx_done after byte 0x55 -> timeout_err=1 at cycle 100 of WAIT_DONE; the next pending requester is then granted normally; a stray tx_done in IDLE has no effect.
6. Reset mid-operation: drive rst=0 during WAIT_DONE with lock=1 -> next cycle state is IDLE, lock=0, all outputs 0; a late tx_done is ignored and a new request from req 0 is accepted.
